uart_gpio_wrapper: RTL and testbench

- Program-load front end for the small SoC.
- Receives 8N1 serial bytes through an internal UART receiver and assembles them little-endian into 32-bit instruction words.
- Writes the words sequentially into an internal instruction memory and raises write_done at the end-of-program sentinel 0xFFFFFFFF.
- Also provides a 4-bit GPIO input/output path that is enabled once loading completes.

---
 rtl/uart_gpio_wrapper.sv | 186 ++++++++++++++++++
 tb/tb_uart_gpio_wrapper.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_gpio_wrapper.sv
`default_nettype none
// =============================================================================
// uart_gpio_wrapper : 8N1 UART program loader into a word-wide instruction memory,
//                     plus a GPIO path gated by write_done. Optional macro: UART_PARITY_EN.
// Rev 1.0
// =============================================================================

module uart_gpio_wrapper #(
   parameter int CLK_HZ       = 50000000,
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8,
   parameter int MEM_DEPTH    = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   input  logic       uart_rx_en,
   output logic       uart_rx_break,
   output logic       uart_rx_valid,
   output logic [7:0] uart_rx_data,
   input  logic [3:0] input_gpio_pins,
   output logic [3:0] output_gpio_pins,
   output logic       write_done
);

   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
   localparam int ADDR_W         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS     = PAYLOAD_BITS + 1;
`else
   localparam int FRAME_BITS     = PAYLOAD_BITS;
`endif
   localparam int BIT_W          = $clog2(FRAME_BITS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   rx_state_t              state, state_next;
   logic                   rxd_meta, rxd_sync;
   logic [3:0]             gpio_meta, gpio_sync;
   logic [CNT_W-1:0]       bit_timer;
   logic [BIT_W-1:0]       bit_idx;
   logic [FRAME_BITS-1:0]  shift;
   logic                   timer_done;
   logic                   frame_end;
   logic                   parity_ok;
   logic                   break_bits;
   logic                   frame_good;
   logic                   frame_break;
   logic [7:0]             payload;

   logic [1:0]             byte_cnt;
   logic [23:0]            word_buf;
   logic [31:0]            word;
   logic                   word_complete;
   logic                   word_wr;
   logic [ADDR_W-1:0]      addr;
   logic [31:0]            mem [MEM_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta  <= 1'b1;
         rxd_sync  <= 1'b1;
         gpio_meta <= 4'd0;
         gpio_sync <= 4'd0;
      end else begin
         rxd_meta  <= uart_rxd;
         rxd_sync  <= rxd_meta;
         gpio_meta <= input_gpio_pins;
         gpio_sync <= gpio_meta;
      end
   end

   always_comb begin
      state_next = state;
      timer_done = 1'b0;
      case (state)
         IDLE: begin
            if (!rxd_sync) state_next = START;
         end
         START: begin
            timer_done = (bit_timer == CNT_W'(HALF_BIT - 1));
            if (timer_done) state_next = rxd_sync ? IDLE : DATA;
         end
         DATA: begin
            timer_done = (bit_timer == CNT_W'(CYCLES_PER_BIT - 1));
            if (timer_done && (bit_idx == BIT_W'(FRAME_BITS - 1))) state_next = STOP;
         end
         STOP: begin
            timer_done = (bit_timer == CNT_W'(CYCLES_PER_BIT - 1));
            if (timer_done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (!uart_rx_en) state_next = IDLE;
   end

   // Frame verdict is taken on the stop-bit sample; shift holds every data/parity bit by then.
   assign frame_end  = (state == STOP) && timer_done && uart_rx_en;
   assign payload    = 8'(shift[PAYLOAD_BITS-1:0]);
`ifdef UART_PARITY_EN
   assign parity_ok  = ~(^shift);
   assign break_bits = (shift == '0);
`else
   assign parity_ok  = 1'b1;
   assign break_bits = (shift[PAYLOAD_BITS-1:0] == '0);
`endif
   assign frame_good  = frame_end && rxd_sync && parity_ok;
   assign frame_break = frame_end && !rxd_sync && break_bits;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         bit_timer     <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         uart_rx_valid <= 1'b0;
         uart_rx_break <= 1'b0;
         uart_rx_data  <= 8'd0;
      end else begin
         state <= state_next;
         if ((state == IDLE) || timer_done || (state_next != state))
            bit_timer <= '0;
         else
            bit_timer <= bit_timer + CNT_W'(1);
         if (state == START) begin
            bit_idx <= '0;
         end else if ((state == DATA) && timer_done) begin
            bit_idx <= bit_idx + BIT_W'(1);
            shift   <= {rxd_sync, shift[FRAME_BITS-1:1]};
         end
         uart_rx_valid <= frame_good;
         uart_rx_break <= frame_break;
         if (frame_good) uart_rx_data <= payload;
      end
   end

   assign word          = {uart_rx_data, word_buf};
   assign word_complete = uart_rx_valid && (byte_cnt == 2'd3);
   assign word_wr       = word_complete && (word != 32'hFFFF_FFFF) && !write_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt   <= 2'd0;
         word_buf   <= 24'd0;
         addr       <= '0;
         write_done <= 1'b0;
      end else begin
         if (uart_rx_break) begin
            byte_cnt <= 2'd0;
         end else if (uart_rx_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
               2'd0:    word_buf[7:0]   <= uart_rx_data;
               2'd1:    word_buf[15:8]  <= uart_rx_data;
               2'd2:    word_buf[23:16] <= uart_rx_data;
               default: ;
            endcase
         end
         if (word_complete && (word == 32'hFFFF_FFFF)) write_done <= 1'b1;
         if (word_wr) begin
            addr <= addr + ADDR_W'(1);
            if (addr == ADDR_W'(MEM_DEPTH - 1)) write_done <= 1'b1;
         end
      end
   end

   // Instruction memory is intentionally left unreset.
   always_ff @(posedge clk) begin
      if (word_wr) mem[addr] <= word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) output_gpio_pins <= 4'd0;
      else     output_gpio_pins <= write_done ? gpio_sync : 4'd0;
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_gpio_wrapper.sv
`default_nettype none
// =============================================================================
// tb_uart_gpio_wrapper : randomized scoreboard bench for the UART program loader.
// Rev 1.0
// =============================================================================

module tb_uart_gpio_wrapper;

   localparam int CLK_HZ   = 1600000;
   localparam int BIT_RATE = 100000;
   localparam int C        = CLK_HZ / BIT_RATE;
   localparam int DEPTH    = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_rxd = 1'b1;
   logic       uart_rx_en = 1'b0;
   logic       uart_rx_break;
   logic       uart_rx_valid;
   logic [7:0] uart_rx_data;
   logic [3:0] input_gpio_pins = 4'd0;
   logic [3:0] output_gpio_pins;
   logic       write_done;

   int checks = 0;
   int errors = 0;

   logic [8:0]  exp_q[$];
   logic [31:0] m_mem [DEPTH];
   bit          m_written [DEPTH];
   int          m_addr;
   bit          m_done;
   int          m_bc;
   logic [31:0] m_buf;
   logic [7:0]  m_last;
   logic [3:0]  m_gpio;

   uart_gpio_wrapper #(
      .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .MEM_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
      .uart_rx_break(uart_rx_break), .uart_rx_valid(uart_rx_valid),
      .uart_rx_data(uart_rx_data), .input_gpio_pins(input_gpio_pins),
      .output_gpio_pins(output_gpio_pins), .write_done(write_done)
   );

   always #5 clk = ~clk;

   initial begin
      #(10 * 80000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every reported event must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && (uart_rx_valid || uart_rx_break)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got valid=%0b break=%0b data=%0h expected none",
                     uart_rx_valid, uart_rx_break, uart_rx_data);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("rx_break", {31'd0, uart_rx_break}, {31'd0, e[8]});
            check("rx_valid", {31'd0, uart_rx_valid}, {31'd0, ~e[8]});
            check("rx_data", {24'd0, uart_rx_data}, {24'd0, e[7:0]});
         end
      end
   end

   task automatic model_reset();
      m_addr = 0;
      m_done = 0;
      m_bc   = 0;
      m_buf  = 32'd0;
      m_last = 8'd0;
      exp_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      m_last = b;
      m_buf[8*m_bc +: 8] = b;
      if (m_bc == 3) begin
         if (m_buf == 32'hFFFF_FFFF) begin
            m_done = 1;
         end else if (!m_done) begin
            m_mem[m_addr]     = m_buf;
            m_written[m_addr] = 1;
            m_addr++;
            if (m_addr == DEPTH) m_done = 1;
         end
      end
      m_bc = (m_bc + 1) % 4;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      uart_rxd = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (C) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      uart_rxd = ^b;
      repeat (C) @(negedge clk);
`endif
      uart_rxd = stop_bit;
      repeat (C) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (C) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      exp_q.push_back({1'b0, b});
      model_byte(b);
      send_frame(b, 1'b1);
   endtask

   task automatic send_break();
      exp_q.push_back({1'b1, m_last});
      m_bc = 0;
      send_frame(8'h00, 1'b0);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic check_state(input string tag);
      repeat (2) @(negedge clk);
      check({tag, ".write_done"}, {31'd0, write_done}, {31'd0, m_done});
      if (m_addr < DEPTH) check({tag, ".addr"}, 32'(dut.addr), 32'(m_addr));
      for (int i = 0; i < DEPTH; i++)
         if (m_written[i]) check($sformatf("%s.mem[%0d]", tag, i), dut.mem[i], m_mem[i]);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic gpio_step(input logic [3:0] v);
      logic [3:0] prev;
      prev = m_done ? m_gpio : 4'd0;
      input_gpio_pins = v;
      m_gpio = v;
      repeat (2) @(negedge clk);
      check("gpio_before_3cyc", {28'd0, output_gpio_pins}, {28'd0, prev});
      @(negedge clk);
      check("gpio_after_3cyc", {28'd0, output_gpio_pins}, {28'd0, m_done ? v : 4'd0});
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom();
      if (w == 32'hFFFF_FFFF) w = 32'd0;
      return w;
   endfunction

   initial begin
      logic [3:0] g;
      for (int i = 0; i < DEPTH; i++) m_written[i] = 0;
      m_gpio = 4'd0;
      model_reset();
      apply_reset();
      uart_rx_en = 1'b1;
      check("reset.valid", {31'd0, uart_rx_valid}, 32'd0);
      check("reset.break", {31'd0, uart_rx_break}, 32'd0);
      check("reset.data", {24'd0, uart_rx_data}, 32'd0);
      check("reset.gpio", {28'd0, output_gpio_pins}, 32'd0);
      check("reset.done", {31'd0, write_done}, 32'd0);
      check("reset.addr", 32'(dut.addr), 32'd0);

      // Single byte; GPIO must stay gated while loading.
      input_gpio_pins = 4'b1010;
      m_gpio = 4'b1010;
      send_byte(8'h13);
      check("gpio_gated", {28'd0, output_gpio_pins}, 32'd0);
      apply_reset();

      send_word(32'hFD010113);
      check_state("w0");
      send_word(32'h02812623);
      check_state("w1");

      // Partial word discarded by BREAK.
      send_byte(8'hAA);
      send_byte(8'h55);
      send_break();
      send_word(32'hDDCCBBAA);
      check_state("after_break");

      // Frame abandoned by dropping the enable produces nothing.
      fork
         send_frame(8'h3C, 1'b1);
         begin
            repeat (3 * C) @(negedge clk);
            uart_rx_en = 1'b0;
         end
      join
      uart_rx_en = 1'b1;
      repeat (3) send_word(rand_word());
      check_state("random_words");

      // Sentinel load and post-done ignore.
      apply_reset();
      send_word(32'h00000000);
      send_word(32'h00000000);
      send_word(32'hFD010113);
      send_word(32'hFFFFFFFF);
      check_state("sentinel");
      send_word(32'h00100793);
      check_state("post_done");

      gpio_step(4'b0111);
      for (int i = 0; i < 3; i++) begin
         g = 4'($urandom_range(1, 15));
         if (g == m_gpio) g = ~g;
         if (g == 4'd0) g = 4'd5;
         gpio_step(g);
      end

      // Asynchronous reset in the middle of a frame.
      uart_rxd = 1'b0;
      repeat (C) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (C + C / 2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst.data", {24'd0, uart_rx_data}, 32'd0);
      check("midrst.gpio", {28'd0, output_gpio_pins}, 32'd0);
      check("midrst.done", {31'd0, write_done}, 32'd0);
      check("midrst.valid", {31'd0, uart_rx_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2 * C) @(negedge clk);
      send_byte(8'h5A);

      // Fill the memory to its last address.
      apply_reset();
      repeat (DEPTH - 1) send_word(rand_word());
      check_state("fill_minus1");
      send_word(rand_word());
      check_state("fill_full");
      send_word(rand_word());
      check_state("fill_over");

      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
